// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants, digit type and validity helper
//
// Contents:
//   BCD_DIGIT_W  width of one BCD digit
//   BCD_MAX      largest legal digit value (9)
//   BCD_ZERO     digit value zero
//   bcd_digit_t  one BCD digit
//   is_bcd()     1 when a digit is in 0..9
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_ZERO    = 4'd0;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational single-digit BCD decrement with borrow chain
//
// Ports:
//   digit       current digit value
//   borrow_in   decrement request from the digit below (or the stage input)
//   next_digit  digit value after the requested decrement
//   borrow_out  request forwarded to the digit above (digit was zero)
//   invalid     digit holds a non-BCD code (A-F)
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t next_digit,
  output logic       borrow_out,
  output logic       invalid
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        // Zero rolls to nine and hands the borrow to the next digit up.
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

  assign invalid = ~is_bcd(digit);

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit synchronous BCD down counter, cascadable
//
// Parameters:
//   DIGITS  number of BCD digits (1..8)
//   WRAP    1: all-zero counts to all-nines; 0: hold at all-zero
// Ports:
//   CLK   rising-edge clock
//   CS    synchronous active-high clear (highest priority)
//   D     parallel load data, digit k at D[4k+3:4k]
//   LD    synchronous parallel load (beats counting)
//   EN    count enable
//   CBI   borrow in from the lower stage (tie high on the first stage)
//   Q     counter value, digit k at Q[4k+3:4k]
//   CBO   borrow out to the next stage, combinational
//   ZERO  Q is all-zero, combinational
//   ERR   registered: Q holds a non-BCD digit; counting is frozen while set
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                        CLK,
  input  logic                        CS,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] D,
  input  logic                        LD,
  input  logic                        EN,
  input  logic                        CBI,
  output logic [BCD_DIGIT_W*DIGITS-1:0] Q,
  output logic                        CBO,
  output logic                        ZERO,
  output logic                        ERR
);

  typedef bcd_digit_t [DIGITS-1:0] bcd_vec_t;

  bcd_vec_t          q_r;
  bcd_vec_t          q_next;
  bcd_vec_t          dec_q;
  bcd_vec_t          d_vec;
  logic              err_r;
  logic              err_next;
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] q_invalid;
  logic [DIGITS-1:0] d_invalid;
  logic              count_ok;
  logic              underflow;

  assign d_vec     = D;
  assign borrow[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_dec u_dec (
      .digit      (q_r[k]),
      .borrow_in  (borrow[k]),
      .next_digit (dec_q[k]),
      .borrow_out (borrow[k+1]),
      .invalid    (q_invalid[k])
    );
    assign d_invalid[k] = ~is_bcd(d_vec[k]);
  end

  // A borrow escaping the top digit means every digit was zero.
  assign underflow = borrow[DIGITS];
  assign count_ok  = EN & CBI & ~err_r;

  always_comb begin
    q_next   = q_r;
    // Q can only hold a bad digit after a bad load, so this tracks ERR on hold/count cycles.
    err_next = |q_invalid;
    if (LD) begin
      q_next   = d_vec;
      err_next = |d_invalid;
    end else if (count_ok && !(underflow && !WRAP)) begin
      q_next = dec_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (CS) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
    end
  end

  assign Q    = q_r;
  assign ERR  = err_r;
  assign ZERO = (q_r == '0);
  assign CBO  = CBI & EN & ZERO & ~err_r;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - self-checking bench: directed plan steps plus random traffic against a decimal model
module tb_bcd_down_counter;

  logic       CLK;
  logic       CS, LD, EN, CBI;
  logic [7:0] D;
  logic [7:0] Q, Qs;
  logic       ZERO, CBO, ERR, ZEROs, CBOs, ERRs;

  logic        c_cs, c_ld, c_en;
  logic [15:0] c_d;
  logic [7:0]  cq_lo, cq_hi;
  logic        c_cbo_lo, c_cbo_hi, c_zero_lo, c_zero_hi, c_err_lo, c_err_hi;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q, s_q;
  logic       m_err, s_err;
  int         cn;
  bit         comb_ok = 0;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut (
    .CLK(CLK), .CS(CS), .D(D), .LD(LD), .EN(EN), .CBI(CBI),
    .Q(Q), .CBO(CBO), .ZERO(ZERO), .ERR(ERR));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_sat (
    .CLK(CLK), .CS(CS), .D(D), .LD(LD), .EN(EN), .CBI(CBI),
    .Q(Qs), .CBO(CBOs), .ZERO(ZEROs), .ERR(ERRs));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_lo (
    .CLK(CLK), .CS(c_cs), .D(c_d[7:0]), .LD(c_ld), .EN(c_en), .CBI(1'b1),
    .Q(cq_lo), .CBO(c_cbo_lo), .ZERO(c_zero_lo), .ERR(c_err_lo));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_hi (
    .CLK(CLK), .CS(c_cs), .D(c_d[15:8]), .LD(c_ld), .EN(c_en), .CBI(c_cbo_lo),
    .Q(cq_hi), .CBO(c_cbo_hi), .ZERO(c_zero_hi), .ERR(c_err_hi));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int bcd2int(input logic [31:0] v, input int nd);
    int n = 0;
    for (int k = nd - 1; k >= 0; k--) n = n * 10 + int'(v[4*k +: 4]);
    return n;
  endfunction

  function automatic logic [31:0] int2bcd(input int n, input int nd);
    logic [31:0] v = '0;
    int          r = n;
    for (int k = 0; k < nd; k++) begin
      v[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  function automatic logic has_bad(input logic [31:0] v, input int nd);
    logic bad = 1'b0;
    for (int k = 0; k < nd; k++) if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Two-digit stage model in plain decimal: returns {err, q}.
  function automatic logic [8:0] ref_next(input logic [7:0] q, input logic e, input bit wrap,
                                          input logic cs, input logic ld, input logic [7:0] d,
                                          input logic en, input logic cbi);
    int          n;
    logic [31:0] b;
    if (cs) return 9'h000;
    if (ld) return {has_bad(32'(d), 2), d};
    if (en && cbi && !e) begin
      n = bcd2int(32'(q), 2);
      if (n == 0) n = wrap ? 99 : 0;
      else n = n - 1;
      b = int2bcd(n, 2);
      return {1'b0, b[7:0]};
    end
    return {e, q};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] nm, ns;
    logic       lo_cbo;
    #1;
    if (comb_ok) begin
      chk("main_zero", 32'(ZERO), 32'(m_q == 8'h00));
      chk("main_cbo", 32'(CBO), 32'(CBI && EN && (m_q == 8'h00) && !m_err));
      chk("sat_zero", 32'(ZEROs), 32'(s_q == 8'h00));
      chk("sat_cbo", 32'(CBOs), 32'(CBI && EN && (s_q == 8'h00) && !s_err));
      lo_cbo = c_en && (cn % 100 == 0);
      chk("casc_lo_cbo", 32'(c_cbo_lo), 32'(lo_cbo));
      chk("casc_hi_cbo", 32'(c_cbo_hi), 32'(lo_cbo && (cn / 100 == 0)));
      chk("casc_lo_zero", 32'(c_zero_lo), 32'(cn % 100 == 0));
      chk("casc_hi_zero", 32'(c_zero_hi), 32'(cn / 100 == 0));
    end
    @(posedge CLK);
    nm = ref_next(m_q, m_err, 1'b1, CS, LD, D, EN, CBI);
    ns = ref_next(s_q, s_err, 1'b0, CS, LD, D, EN, CBI);
    {m_err, m_q} = nm;
    {s_err, s_q} = ns;
    if (c_cs)      cn = 0;
    else if (c_ld) cn = bcd2int(32'(c_d), 4);
    else if (c_en) cn = (cn == 0) ? 9999 : cn - 1;
    comb_ok = 1;
    #1;
    chk("main_q", 32'(Q), 32'(m_q));
    chk("main_err", 32'(ERR), 32'(m_err));
    chk("sat_q", 32'(Qs), 32'(s_q));
    chk("sat_err", 32'(ERRs), 32'(s_err));
    chk("casc_q", 32'({cq_hi, cq_lo}), int2bcd(cn, 4));
    chk("casc_err", 32'({c_err_hi, c_err_lo}), 32'd0);
  endtask

  initial begin
    CS = 1'b1; LD = 1'b0; EN = 1'b0; CBI = 1'b0; D = 8'h00;
    c_cs = 1'b1; c_ld = 1'b0; c_en = 1'b0; c_d = 16'h0000;
    m_q = 8'h00; s_q = 8'h00; m_err = 1'b0; s_err = 1'b0; cn = 0;
    @(negedge CLK);

    // Clear, then free-run from 00 through the wrap.
    tick();
    chk("reset_q", 32'(Q), 32'h00);
    chk("reset_zero", 32'(ZERO), 32'd1);
    CS = 1'b0; c_cs = 1'b0; EN = 1'b1; CBI = 1'b1;
    #1;
    chk("cbo_at_00", 32'(CBO), 32'd1);
    tick();
    chk("wrap_99", 32'(Q), 32'h99);
    tick();
    tick();
    chk("count_97", 32'(Q), 32'h97);
    chk("sat_stays_00", 32'(Qs), 32'h00);

    // Borrow from digit 1 at 10 -> 09.
    LD = 1'b1; D = 8'h10;
    tick();
    LD = 1'b0;
    tick();
    chk("borrow_09", 32'(Q), 32'h09);
    tick();
    chk("count_08", 32'(Q), 32'h08);

    // Cascade of two stages.
    EN = 1'b0;
    c_ld = 1'b1; c_d = 16'h0100;
    tick();
    c_ld = 1'b0; c_en = 1'b1;
    tick();
    chk("casc_0099", 32'({cq_hi, cq_lo}), 32'h0099);
    c_ld = 1'b1; c_d = 16'h0000; c_en = 1'b0;
    tick();
    c_ld = 1'b0; c_en = 1'b1;
    #1;
    chk("casc_both_cbo", 32'({c_cbo_hi, c_cbo_lo}), 32'h3);
    tick();
    chk("casc_9999", 32'({cq_hi, cq_lo}), 32'h9999);
    c_en = 1'b0;

    // Saturating stage held at zero.
    CS = 1'b1;
    tick();
    CS = 1'b0; EN = 1'b1; CBI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_cbo_hold", 32'(CBOs), 32'd1);
      tick();
      chk("sat_q_hold", 32'(Qs), 32'h00);
    end

    // Non-BCD load freezes the counter until a valid load.
    LD = 1'b1; D = 8'h3C;
    tick();
    chk("bad_load_err", 32'(ERR), 32'd1);
    LD = 1'b0;
    tick();
    tick();
    chk("err_hold_q", 32'(Q), 32'h3C);
    chk("err_cbo", 32'(CBO), 32'd0);
    LD = 1'b1; D = 8'h25;
    tick();
    chk("good_load_err", 32'(ERR), 32'd0);
    LD = 1'b0;
    tick();
    chk("after_err_24", 32'(Q), 32'h24);

    // Priority: clear over load, load over count.
    LD = 1'b1; D = 8'h50;
    tick();
    CS = 1'b1; D = 8'h77;
    tick();
    chk("cs_beats_ld", 32'(Q), 32'h00);
    CS = 1'b0;
    tick();
    chk("ld_beats_count", 32'(Q), 32'h77);
    LD = 1'b0;
    tick();
    chk("en_on_76", 32'(Q), 32'h76);
    EN = 1'b0;
    tick();
    chk("en_off_76", 32'(Q), 32'h76);
    EN = 1'b1;
    tick();
    chk("en_on_75", 32'(Q), 32'h75);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      CS  = ($urandom_range(15) == 0);
      LD  = ($urandom_range(5) == 0);
      EN  = ($urandom_range(3) != 0);
      CBI = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) D = 8'($urandom);
      else D = {4'($urandom_range(9)), 4'($urandom_range(9))};
      c_cs = ($urandom_range(31) == 0);
      c_ld = ($urandom_range(7) == 0);
      c_en = ($urandom_range(3) != 0);
      c_d  = int2bcd(int'($urandom_range(9999)), 4);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
